// File: rtl/fml_arb_pkg.sv
// Shared types and constants for the two-requester DDR FML arbiter.
package fml_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/fml_arb_watchdog.sv
// Saturating ack-timeout and lock-length counters with sticky error flags.
module fml_arb_watchdog
  import fml_arb_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int MAX_LOCK = 8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic busy,
  input  logic stb,
  input  logic ack,
  input  logic lock,
  input  logic clr_err,
  output logic timeout_err,
  output logic lock_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int LK_W = $clog2(MAX_LOCK + 1);

  logic [TO_W-1:0] to_cnt;
  logic [LK_W-1:0] lock_cnt;
  logic            to_hit;
  logic            lock_hit;

  // Flags fire only on the count step that reaches the limit, so clr_err
  // can clear them while a saturated condition persists.
  assign to_hit   = busy && stb && !ack && (to_cnt == TO_W'(TIMEOUT - 1));
  assign lock_hit = busy && ack && lock && (lock_cnt == LK_W'(MAX_LOCK - 1));

  // Stalled-strobe counter: runs while strobing without ack, clears on ack or idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt <= '0;
    end else if (!busy || ack) begin
      to_cnt <= '0;
    end else if (stb && (to_cnt != TO_W'(TIMEOUT))) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Locked-ack counter: counts acks taken with lock held, clears on unlocked ack.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_cnt <= '0;
    end else if (!busy) begin
      lock_cnt <= '0;
    end else if (ack) begin
      if (!lock) begin
        lock_cnt <= '0;
      end else if (lock_cnt != LK_W'(MAX_LOCK)) begin
        lock_cnt <= lock_cnt + LK_W'(1);
      end
    end
  end

  // Sticky flags; a set in the same cycle as clr_err takes priority.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timeout_err <= 1'b0;
      lock_err    <= 1'b0;
    end else begin
      if (to_hit)       timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
      if (lock_hit)     lock_err    <= 1'b1;
      else if (clr_err) lock_err    <= 1'b0;
    end
  end

endmodule

// File: rtl/fml_ddr_arbiter.sv
// Round-robin arbiter sharing one DDR FML slave port between two requesters.
module fml_ddr_arbiter
  import fml_arb_pkg::*;
#(
  parameter int ADR_W    = 26,
  parameter int TIMEOUT  = 255,
  parameter int MAX_LOCK = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [3:0]       m0_sel,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [31:0]      m0_do,
  input  logic             m0_lock,
  output logic             m0_ack,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [3:0]       m1_sel,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [31:0]      m1_do,
  input  logic             m1_lock,
  output logic             m1_ack,
  output logic [31:0]      m_di,
  output logic             fml_stb,
  output logic             fml_we,
  output logic [3:0]       fml_sel,
  output logic [ADR_W-1:0] fml_adr,
  output logic [31:0]      fml_do,
  input  logic             fml_ack,
  input  logic [31:0]      fml_di,
  output logic [1:0]       owner,
  output logic             timeout_err,
  output logic             lock_err,
  input  logic             clr_err
);

  state_t state, state_nxt;
  logic   own_idx, own_idx_nxt;
  logic   rr_last, rr_last_nxt;
  logic   grant;
  logic   busy;
  logic   own_stb;
  logic   own_lock;

  assign busy     = (state == ST_BUSY);
  assign own_stb  = (own_idx == OWNER_M1) ? m1_stb  : m0_stb;
  assign own_lock = (own_idx == OWNER_M1) ? m1_lock : m0_lock;

  // State, owner and round-robin pointer registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      own_idx <= OWNER_M0;
      rr_last <= OWNER_M1;
    end else begin
      state   <= state_nxt;
      own_idx <= own_idx_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  // Next-state: grant in IDLE, hold under lock in BUSY, one dead cycle in GAP.
  always_comb begin
    state_nxt   = state;
    own_idx_nxt = own_idx;
    rr_last_nxt = rr_last;
    grant       = OWNER_M0;
    case (state)
      ST_IDLE: begin
        if (m0_stb || m1_stb) begin
          grant       = (m0_stb && m1_stb) ? ~rr_last : m1_stb;
          own_idx_nxt = grant;
          rr_last_nxt = grant;
          state_nxt   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (fml_ack) begin
          state_nxt = own_lock ? ST_BUSY : ST_GAP;
        end else if (!own_stb && !own_lock) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Owner-side mux toward the DDR port and ack steering back to the owner.
  always_comb begin
    fml_stb = busy && own_stb;
    fml_we  = (own_idx == OWNER_M1) ? m1_we  : m0_we;
    fml_sel = (own_idx == OWNER_M1) ? m1_sel : m0_sel;
    fml_adr = (own_idx == OWNER_M1) ? m1_adr : m0_adr;
    fml_do  = (own_idx == OWNER_M1) ? m1_do  : m0_do;
    m0_ack  = busy && (own_idx == OWNER_M0) && fml_ack;
    m1_ack  = busy && (own_idx == OWNER_M1) && fml_ack;
    m_di    = fml_di;
    owner   = {own_idx, busy};
  end

  fml_arb_watchdog #(
    .TIMEOUT  (TIMEOUT),
    .MAX_LOCK (MAX_LOCK)
  ) u_watchdog (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .busy        (busy),
    .stb         (fml_stb),
    .ack         (fml_ack),
    .lock        (own_lock),
    .clr_err     (clr_err),
    .timeout_err (timeout_err),
    .lock_err    (lock_err)
  );

endmodule

// File: tb/tb_fml_ddr_arbiter.sv
// Bench for fml_ddr_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_fml_ddr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_stb, m0_we, m0_lock, m0_ack;
  logic [3:0]  m0_sel;
  logic [25:0] m0_adr;
  logic [31:0] m0_do;
  logic        m1_stb, m1_we, m1_lock, m1_ack;
  logic [3:0]  m1_sel;
  logic [25:0] m1_adr;
  logic [31:0] m1_do;
  logic [31:0] m_di;
  logic        fml_stb, fml_we, fml_ack;
  logic [3:0]  fml_sel;
  logic [25:0] fml_adr;
  logic [31:0] fml_do, fml_di;
  logic [1:0]  owner;
  logic        timeout_err, lock_err, clr_err;

  fml_ddr_arbiter #(.ADR_W(26), .TIMEOUT(255), .MAX_LOCK(8)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_do(m0_do), .m0_lock(m0_lock), .m0_ack(m0_ack),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_do(m1_do), .m1_lock(m1_lock), .m1_ack(m1_ack),
    .m_di(m_di), .fml_stb(fml_stb), .fml_we(fml_we), .fml_sel(fml_sel),
    .fml_adr(fml_adr), .fml_do(fml_do), .fml_ack(fml_ack), .fml_di(fml_di),
    .owner(owner), .timeout_err(timeout_err), .lock_err(lock_err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s0, l0, s1, l1, ack;
    logic [25:0] adr1;
    logic [31:0] di;
    logic        efstb;
    logic [1:0]  eown;
    logic        ea0, ea1;
    logic [25:0] eadr;
  } vec_t;

  typedef struct {
    logic        idx;
    logic [31:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void v(input logic s0, l0, s1, l1, ack, input logic [25:0] adr1,
                            input logic [31:0] di, input logic efstb, input logic [1:0] eown,
                            input logic ea0, ea1, input logic [25:0] eadr);
    vec_t r;
    r.s0 = s0; r.l0 = l0; r.s1 = s1; r.l1 = l1; r.ack = ack; r.adr1 = adr1; r.di = di;
    r.efstb = efstb; r.eown = eown; r.ea0 = ea0; r.ea1 = ea1; r.eadr = eadr;
    vecs.push_back(r);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_stb = 0; m0_lock = 0; m1_stb = 0; m1_lock = 0; fml_ack = 0; clr_err = 0;
  endtask

  task automatic push_sb(input logic idx, input logic [31:0] data);
    sb_t e;
    e.idx = idx; e.data = data;
    sbq.push_back(e);
  endtask

  // Ack monitor: every requester ack must match the next expected transfer.
  always @(negedge clk) begin
    if (rst_n && (m0_ack || m1_ack)) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_ack", 64'({m1_ack, m0_ack}), 64'(0));
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_ack_idx", 64'({m1_ack, m0_ack}), 64'(e.idx ? 2'b10 : 2'b01));
        chk("sb_m_di", 64'(m_di), 64'(e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    m0_we = 0; m0_sel = 4'h3; m0_adr = 26'h100; m0_do = 32'hD0D0_0000;
    m1_we = 1; m1_sel = 4'hC; m1_adr = 26'h200; m1_do = 32'hD1D1_1111;
    fml_di = '0;
    idle_in();
    rst_n = 0;

    // contention: both request, grants alternate 0,1,0,1
    v(1,0,1,0,0,'h200,0,          0,2'b00,0,0,0);
    v(1,0,1,0,0,'h200,0,          1,2'b01,0,0,'h100);
    v(1,0,1,0,1,'h200,'h1111,     1,2'b01,1,0,'h100);
    v(1,0,1,0,0,'h200,0,          0,2'b00,0,0,0);
    v(1,0,1,0,0,'h200,0,          0,2'b00,0,0,0);
    v(1,0,1,0,0,'h200,0,          1,2'b11,0,0,'h200);
    v(1,0,1,0,1,'h200,'h2222,     1,2'b11,0,1,'h200);
    v(1,0,1,0,0,'h200,0,          0,2'b10,0,0,0);
    v(1,0,1,0,0,'h200,0,          0,2'b10,0,0,0);
    v(1,0,1,0,0,'h200,0,          1,2'b01,0,0,'h100);
    v(1,0,1,0,1,'h200,'h3333,     1,2'b01,1,0,'h100);
    v(0,0,1,0,0,'h200,0,          0,2'b00,0,0,0);
    v(0,0,1,0,0,'h200,0,          0,2'b00,0,0,0);
    v(0,0,1,0,0,'h200,0,          1,2'b11,0,0,'h200);
    v(0,0,1,0,1,'h200,'h4444,     1,2'b11,0,1,'h200);
    v(0,0,0,0,0,'h200,0,          0,2'b10,0,0,0);
    v(0,0,0,0,0,'h200,0,          0,2'b10,0,0,0);
    // single m0 read, ack 3 cycles after grant, stb held through GAP
    v(1,0,0,0,0,'h200,0,          0,2'b10,0,0,0);
    v(1,0,0,0,0,'h200,0,          1,2'b01,0,0,'h100);
    v(1,0,0,0,0,'h200,0,          1,2'b01,0,0,'h100);
    v(1,0,0,0,1,'h200,'hA5A5,     1,2'b01,1,0,'h100);
    v(1,0,0,0,0,'h200,0,          0,2'b00,0,0,0);
    v(0,0,0,0,0,'h200,0,          0,2'b00,0,0,0);
    // locked pair on m1 with m0 waiting
    v(1,0,1,1,0,'h10,0,           0,2'b00,0,0,0);
    v(1,0,1,1,0,'h10,0,           1,2'b11,0,0,'h10);
    v(1,0,1,1,1,'h10,'h5555,      1,2'b11,0,1,'h10);
    v(1,0,0,1,0,'h12,0,           0,2'b11,0,0,0);
    v(1,0,1,0,0,'h12,0,           1,2'b11,0,0,'h12);
    v(1,0,1,0,1,'h12,'h6666,      1,2'b11,0,1,'h12);
    v(1,0,0,0,0,'h200,0,          0,2'b10,0,0,0);
    v(1,0,0,0,0,'h200,0,          0,2'b10,0,0,0);
    v(1,0,0,0,0,'h200,0,          1,2'b01,0,0,'h100);
    v(1,0,0,0,1,'h200,'h7777,     1,2'b01,1,0,'h100);
    v(0,0,0,0,0,'h200,0,          0,2'b00,0,0,0);
    v(0,0,0,0,0,'h200,0,          0,2'b00,0,0,0);
    // abort: m1 drops stb before ack
    v(0,0,1,0,0,'h200,0,          0,2'b00,0,0,0);
    v(0,0,1,0,0,'h200,0,          1,2'b11,0,0,'h200);
    v(0,0,0,0,0,'h200,0,          0,2'b11,0,0,0);
    v(0,0,0,0,0,'h200,0,          0,2'b10,0,0,0);
    // ack in the same cycle the owner drops stb
    v(1,0,0,0,0,'h200,0,          0,2'b10,0,0,0);
    v(1,0,0,0,0,'h200,0,          1,2'b01,0,0,'h100);
    v(0,0,0,0,1,'h200,'h8888,     0,2'b01,1,0,0);
    v(0,0,0,0,0,'h200,0,          0,2'b00,0,0,0);
    v(0,0,0,0,0,'h200,0,          0,2'b00,0,0,0);

    repeat (3) @(negedge clk);
    chk("rst_fml_stb", 64'(fml_stb), 64'(0));
    chk("rst_owner", 64'(owner), 64'(0));
    chk("rst_acks", 64'({m0_ack, m1_ack}), 64'(0));
    chk("rst_flags", 64'({timeout_err, lock_err}), 64'(0));
    @(posedge clk); #1; rst_n = 1;

    foreach (vecs[i]) begin
      cyc();
      m0_stb = vecs[i].s0; m0_lock = vecs[i].l0;
      m1_stb = vecs[i].s1; m1_lock = vecs[i].l1;
      m1_adr = vecs[i].adr1; fml_ack = vecs[i].ack; fml_di = vecs[i].di;
      if (vecs[i].ack && (vecs[i].ea0 || vecs[i].ea1)) push_sb(vecs[i].ea1, vecs[i].di);
      @(negedge clk);
      chk($sformatf("row%0d_fml_stb", i), 64'(fml_stb), 64'(vecs[i].efstb));
      chk($sformatf("row%0d_owner", i), 64'(owner), 64'(vecs[i].eown));
      chk($sformatf("row%0d_acks", i), 64'({m0_ack, m1_ack}), 64'({vecs[i].ea0, vecs[i].ea1}));
      if (vecs[i].efstb) begin
        chk($sformatf("row%0d_fml_adr", i), 64'(fml_adr), 64'(vecs[i].eadr));
        chk($sformatf("row%0d_fml_mux", i), 64'({fml_we, fml_sel, fml_do}),
            vecs[i].eown[1] ? 64'({1'b1, 4'hC, 32'hD1D1_1111}) : 64'({1'b0, 4'h3, 32'hD0D0_0000}));
      end
    end
    chk("table_flags", 64'({timeout_err, lock_err}), 64'(0));

    // timeout watchdog: 255 stalled cycles, grant kept, then clr_err
    m1_adr = 26'h200;
    cyc(); idle_in(); m0_stb = 1;
    @(negedge clk); chk("wd_idle", 64'(fml_stb), 64'(0));
    cyc(); @(negedge clk); chk("wd_busy", 64'({fml_stb, owner}), 64'(3'b101));
    for (int i = 2; i <= 255; i++) begin
      cyc(); @(negedge clk);
    end
    chk("wd_to_before", 64'(timeout_err), 64'(0));
    cyc(); @(negedge clk);
    chk("wd_to_set", 64'(timeout_err), 64'(1));
    chk("wd_grant_kept", 64'({fml_stb, owner}), 64'(3'b101));
    cyc(); clr_err = 1; @(negedge clk);
    chk("wd_to_hold", 64'(timeout_err), 64'(1));
    cyc(); clr_err = 0; @(negedge clk);
    chk("wd_to_clr", 64'(timeout_err), 64'(0));
    chk("wd_still_busy", 64'({fml_stb, owner}), 64'(3'b101));
    cyc(); fml_ack = 1; fml_di = 32'h9999; push_sb(0, 32'h9999); @(negedge clk);
    chk("wd_ack", 64'(m0_ack), 64'(1));
    cyc(); fml_ack = 0; m0_stb = 0; @(negedge clk);
    cyc(); @(negedge clk);

    // lock overrun: 8 locked acks on m1, clr_err on the 8th loses to the set
    cyc(); m1_stb = 1; m1_lock = 1; m1_adr = 26'h300; @(negedge clk);
    cyc(); @(negedge clk); chk("lk_busy", 64'(owner), 64'(2'b11));
    for (int k = 1; k <= 8; k++) begin
      cyc(); fml_ack = 1; fml_di = 32'(k); clr_err = (k == 8); push_sb(1, 32'(k));
      @(negedge clk);
    end
    chk("lk_before", 64'(lock_err), 64'(0));
    cyc(); fml_ack = 0; clr_err = 0; @(negedge clk);
    chk("lk_set", 64'(lock_err), 64'(1));
    chk("lk_grant_kept", 64'({fml_stb, owner, fml_adr}), 64'({1'b1, 2'b11, 26'h300}));
    cyc(); m1_lock = 0; fml_ack = 1; fml_di = 32'hAAAA; push_sb(1, 32'hAAAA); @(negedge clk);
    cyc(); fml_ack = 0; m1_stb = 0; @(negedge clk);
    chk("lk_gap", 64'({fml_stb, owner}), 64'(3'b010));
    cyc(); @(negedge clk);

    // asynchronous reset in the middle of a transfer
    cyc(); m0_stb = 1; @(negedge clk);
    cyc(); @(negedge clk); chk("rm_busy", 64'({fml_stb, owner}), 64'(3'b101));
    #2; fml_ack = 1; rst_n = 0; #1;
    chk("rm_fml_stb", 64'(fml_stb), 64'(0));
    chk("rm_acks", 64'({m0_ack, m1_ack}), 64'(0));
    chk("rm_owner", 64'(owner), 64'(0));
    chk("rm_flags", 64'({timeout_err, lock_err}), 64'(0));
    cyc(); fml_ack = 0; m1_stb = 1; @(negedge clk);
    cyc(); rst_n = 1; @(negedge clk);
    chk("rm_idle", 64'({fml_stb, owner}), 64'(0));
    cyc(); @(negedge clk);
    chk("rm_m0_first", 64'({fml_stb, owner}), 64'(3'b101));
    cyc(); fml_ack = 1; fml_di = 32'hBBBB; push_sb(0, 32'hBBBB); @(negedge clk);
    cyc(); idle_in(); @(negedge clk);
    cyc(); @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
